// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-port arbiter: requester IDs, FSM states, default widths.
package mem_arbiter_pkg;
   localparam int DEF_AW = 16;
   localparam int DEF_DW = 16;

   typedef enum logic [1:0] {
      REQ_NONE = 2'd0,
      REQ_S4   = 2'd1,
      REQ_F    = 2'd2,
      REQ_IO   = 2'd3
   } req_id_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } state_t;
endpackage

// File: rtl/mem_arbiter_arb_prio3.sv
// Combinational three-way picker: S4 > FETCH > IO, with an override that forces IO
// to win whenever it is requesting. Winner bit order is {IO, FETCH, S4}.
module arb_prio3
   import mem_arbiter_pkg::*;
(
   input  logic       req_s4,
   input  logic       req_f,
   input  logic       req_io,
   input  logic       ovr,
   output logic [2:0] win,
   output req_id_t    id
);

   always_comb begin
      win = 3'b000;
      id  = REQ_NONE;
      if (ovr && req_io) begin
         win = 3'b100;
         id  = REQ_IO;
      end else if (req_s4) begin
         win = 3'b001;
         id  = REQ_S4;
      end else if (req_f) begin
         win = 3'b010;
         id  = REQ_F;
      end else if (req_io) begin
         win = 3'b100;
         id  = REQ_IO;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter for the CPU-side memory port: fetch, stage-4 and IO
// requesters share one port; grants, strobes and read returns are all registered.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AW           = DEF_AW,
   parameter int DW           = DEF_DW,
   parameter int READ_LAT     = 1,
   parameter int STARVE_LIMIT = 8
) (
   input  logic          CLK,
   input  logic          RSTN,
   input  logic          F_REQ,
   input  logic [AW-1:0] F_ADDR,
   output logic          F_GNT,
   output logic          F_RVALID,
   input  logic          S4_REQ,
   input  logic          S4_WE,
   input  logic [AW-1:0] S4_ADDR,
   input  logic [DW-1:0] S4_WDATA,
   output logic          S4_GNT,
   output logic          S4_RVALID,
   input  logic          IO_REQ,
   input  logic          IO_WE,
   input  logic [AW-1:0] IO_ADDR,
   input  logic [DW-1:0] IO_WDATA,
   output logic          IO_GNT,
   output logic          IO_RVALID,
   output logic [DW-1:0] RDATA,
   output logic          MEM_EN,
   output logic          MEM_WE,
   output logic [AW-1:0] MEM_ADDR,
   output logic [DW-1:0] MEM_WDATA,
   input  logic [DW-1:0] MEM_RDATA,
   output logic          BUSY
);

   localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);
   localparam logic [1:0] LAT_LAST   = 2'(READ_LAT - 1);

   state_t        state, state_nxt;
   req_id_t       win_id, owner;
   logic [2:0]    win_oh;
   logic          ovr, any_req;
   logic [7:0]    starve_cnt;
   logic [1:0]    lat_cnt;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   assign ovr     = IO_REQ && (starve_cnt == STARVE_MAX);
   assign any_req = |win_oh;
   assign BUSY    = (state != IDLE);

   arb_prio3 u_prio (
      .req_s4 (S4_REQ),
      .req_f  (F_REQ),
      .req_io (IO_REQ),
      .ovr    (ovr),
      .win    (win_oh),
      .id     (win_id)
   );

   // Fetch is read-only; its write data is irrelevant, so the port keeps its last value.
   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = F_ADDR;
      sel_wdata = MEM_WDATA;
      if (win_oh[0]) begin
         sel_we    = S4_WE;
         sel_addr  = S4_ADDR;
         sel_wdata = S4_WDATA;
      end else if (win_oh[2]) begin
         sel_we    = IO_WE;
         sel_addr  = IO_ADDR;
         sel_wdata = IO_WDATA;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (any_req) state_nxt = ISSUE;
         ISSUE:   state_nxt = MEM_WE ? IDLE : WAIT;
         WAIT:    if (lat_cnt == LAT_LAST) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         F_GNT      <= 1'b0;
         S4_GNT     <= 1'b0;
         IO_GNT     <= 1'b0;
         F_RVALID   <= 1'b0;
         S4_RVALID  <= 1'b0;
         IO_RVALID  <= 1'b0;
         MEM_EN     <= 1'b0;
         MEM_WE     <= 1'b0;
         MEM_ADDR   <= '0;
         MEM_WDATA  <= '0;
         RDATA      <= '0;
         owner      <= REQ_NONE;
         starve_cnt <= '0;
         lat_cnt    <= '0;
      end else begin
         F_GNT     <= 1'b0;
         S4_GNT    <= 1'b0;
         IO_GNT    <= 1'b0;
         F_RVALID  <= 1'b0;
         S4_RVALID <= 1'b0;
         IO_RVALID <= 1'b0;
         MEM_EN    <= 1'b0;
         MEM_WE    <= 1'b0;
         unique case (state)
            IDLE: begin
               lat_cnt <= '0;
               // Age only while IO is actually waiting and loses this round.
               if (!IO_REQ || win_oh[2])          starve_cnt <= '0;
               else if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 8'd1;
               if (any_req) begin
                  owner     <= win_id;
                  S4_GNT    <= win_oh[0];
                  F_GNT     <= win_oh[1];
                  IO_GNT    <= win_oh[2];
                  MEM_EN    <= 1'b1;
                  MEM_WE    <= sel_we;
                  MEM_ADDR  <= sel_addr;
                  MEM_WDATA <= sel_wdata;
               end
            end
            WAIT: begin
               lat_cnt <= lat_cnt + 2'd1;
               if (lat_cnt == LAT_LAST) begin
                  RDATA     <= MEM_RDATA;
                  S4_RVALID <= (owner == REQ_S4);
                  F_RVALID  <= (owner == REQ_F);
                  IO_RVALID <= (owner == REQ_IO);
               end
            end
            default: lat_cnt <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a transaction-level model predicts grants
// and read returns per cycle; an independent monitor compares them against the DUT.
module tb_mem_arbiter;

   localparam int AW   = 16;
   localparam int DW   = 16;
   localparam int LAT  = 1;
   localparam int SLIM = 4;

   typedef struct {
      int            cyc;
      int            id;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } ev_t;

   logic CLK = 1'b0;
   logic RSTN = 1'b0;
   logic F_REQ, S4_REQ, S4_WE, IO_REQ, IO_WE;
   logic [AW-1:0] F_ADDR, S4_ADDR, IO_ADDR;
   logic [DW-1:0] S4_WDATA, IO_WDATA;
   logic F_GNT, F_RVALID, S4_GNT, S4_RVALID, IO_GNT, IO_RVALID;
   logic [DW-1:0] RDATA, MEM_WDATA;
   logic [DW-1:0] mem_rdata = '0;
   logic [AW-1:0] MEM_ADDR;
   logic MEM_EN, MEM_WE, BUSY;

   mem_arbiter #(.AW(AW), .DW(DW), .READ_LAT(LAT), .STARVE_LIMIT(SLIM)) dut (
      .CLK(CLK), .RSTN(RSTN),
      .F_REQ(F_REQ), .F_ADDR(F_ADDR), .F_GNT(F_GNT), .F_RVALID(F_RVALID),
      .S4_REQ(S4_REQ), .S4_WE(S4_WE), .S4_ADDR(S4_ADDR), .S4_WDATA(S4_WDATA),
      .S4_GNT(S4_GNT), .S4_RVALID(S4_RVALID),
      .IO_REQ(IO_REQ), .IO_WE(IO_WE), .IO_ADDR(IO_ADDR), .IO_WDATA(IO_WDATA),
      .IO_GNT(IO_GNT), .IO_RVALID(IO_RVALID),
      .RDATA(RDATA), .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
      .MEM_WDATA(MEM_WDATA), .MEM_RDATA(mem_rdata), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc++;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] seed(input int a);
      return (a == 16) ? 16'hABCD : 16'(a * 40503 + 7);
   endfunction

   // Memory behind the port: one-cycle read latency, untouched words read as seed().
   logic [DW-1:0] mem [int];
   always @(posedge CLK) begin
      if (MEM_EN) begin
         if (MEM_WE) mem[int'(MEM_ADDR)] = MEM_WDATA;
         else mem_rdata <= mem.exists(int'(MEM_ADDR)) ? mem[int'(MEM_ADDR)] : seed(int'(MEM_ADDR));
      end
   end

   // Reference model: the port is free from free_cyc on; a request seen then wins
   // per priority/aging rules and its grant and read return land at fixed offsets.
   ev_t gq[$];
   ev_t vq[$];
   logic [DW-1:0] ref_mem [int];
   int   free_cyc = 0;
   int   starve = 0;
   logic exp_busy = 1'b0;
   int   m_w;
   ev_t  m_g, m_v;

   initial forever begin
      @(negedge CLK);
      exp_busy = (cyc < free_cyc);
      if (!RSTN) begin
         while (gq.size() > 0 && gq[$].cyc > cyc) void'(gq.pop_back());
         while (vq.size() > 0 && vq[$].cyc > cyc) void'(vq.pop_back());
         free_cyc = cyc + 1;
         starve = 0;
      end else if (cyc >= free_cyc) begin
         if (S4_REQ || F_REQ || IO_REQ) begin
            if (IO_REQ && starve == SLIM) m_w = 2;
            else if (S4_REQ)              m_w = 0;
            else if (F_REQ)               m_w = 1;
            else                          m_w = 2;
            starve = (IO_REQ && m_w != 2) ? ((starve < SLIM) ? starve + 1 : SLIM) : 0;
            m_g.cyc = cyc + 1;
            m_g.id  = m_w;
            case (m_w)
               0: begin m_g.we = S4_WE; m_g.addr = S4_ADDR; m_g.data = S4_WDATA; end
               1: begin m_g.we = 1'b0;  m_g.addr = F_ADDR;  m_g.data = '0;       end
               default: begin m_g.we = IO_WE; m_g.addr = IO_ADDR; m_g.data = IO_WDATA; end
            endcase
            gq.push_back(m_g);
            if (m_g.we) begin
               ref_mem[int'(m_g.addr)] = m_g.data;
               free_cyc = cyc + 2;
            end else begin
               m_v.cyc  = cyc + 2 + LAT;
               m_v.id   = m_w;
               m_v.we   = 1'b0;
               m_v.addr = m_g.addr;
               m_v.data = ref_mem.exists(int'(m_g.addr)) ? ref_mem[int'(m_g.addr)] : seed(int'(m_g.addr));
               vq.push_back(m_v);
               free_cyc = cyc + 2 + LAT;
            end
         end else begin
            starve = 0;
         end
      end
   end

   // Monitor: compares every cycle's grant/rvalid vectors against the expectation queues.
   bit         armed = 0, prev_rst = 0, have_g, have_v;
   logic [2:0] act_g, act_v, exp_g, exp_v;
   ev_t        ge, ve;

   initial forever begin
      @(negedge CLK);
      #2;
      if (!armed) begin
         armed = !RSTN;
         prev_rst = !RSTN;
         continue;
      end
      act_g = {IO_GNT, F_GNT, S4_GNT};
      act_v = {IO_RVALID, F_RVALID, S4_RVALID};
      if (prev_rst) begin
         chk("reset_strobes", 32'({act_g, act_v, MEM_EN, MEM_WE, BUSY}), 32'd0);
         chk("reset_addr_wdata", {MEM_ADDR, MEM_WDATA}, 32'd0);
         chk("reset_rdata", 32'(RDATA), 32'd0);
      end
      chk("one_gnt", 32'($countones(act_g) <= 1), 32'd1);
      chk("one_rvalid", 32'($countones(act_v) <= 1), 32'd1);
      have_g = (gq.size() > 0 && gq[0].cyc == cyc);
      exp_g = 3'b000;
      if (have_g) begin
         ge = gq.pop_front();
         exp_g = 3'b001 << ge.id;
      end
      chk("gnt", 32'(act_g), 32'(exp_g));
      chk("mem_en", 32'(MEM_EN), 32'(have_g));
      if (have_g) begin
         chk("mem_we", 32'(MEM_WE), 32'(ge.we));
         chk("mem_addr", 32'(MEM_ADDR), 32'(ge.addr));
         if (ge.we) chk("mem_wdata", 32'(MEM_WDATA), 32'(ge.data));
      end
      have_v = (vq.size() > 0 && vq[0].cyc == cyc);
      exp_v = 3'b000;
      if (have_v) begin
         ve = vq.pop_front();
         exp_v = 3'b001 << ve.id;
      end
      chk("rvalid", 32'(act_v), 32'(exp_v));
      if (have_v) chk("rdata", 32'(RDATA), 32'(ve.data));
      chk("busy", 32'(BUSY), 32'(exp_busy));
      prev_rst = !RSTN;
   end

   // Requester agents: 0 = S4, 1 = FETCH, 2 = IO. REQ drops the cycle after GNT unless held.
   logic [2:0] hold = '0, last_g = '0, last_v = '0;
   bit         rnd = 0;
   int         rv_total = 0;

   task automatic raise(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      case (i)
         0: begin S4_REQ = 1'b1; S4_WE = w; S4_ADDR = a; S4_WDATA = d; end
         1: begin F_REQ = 1'b1; F_ADDR = a; end
         default: begin IO_REQ = 1'b1; IO_WE = w; IO_ADDR = a; IO_WDATA = d; end
      endcase
   endtask

   task automatic scramble(input int i);
      case (i)
         0: begin S4_WE = 1'($urandom); S4_ADDR = 16'($urandom); S4_WDATA = 16'($urandom); end
         1: F_ADDR = 16'($urandom);
         default: begin IO_WE = 1'($urandom); IO_ADDR = 16'($urandom); IO_WDATA = 16'($urandom); end
      endcase
   endtask

   task automatic step();
      logic [2:0] drop, cur;
      @(posedge CLK);
      #1;
      drop = last_g & ~hold;
      if (drop[0]) S4_REQ = 1'b0;
      if (drop[1]) F_REQ = 1'b0;
      if (drop[2]) IO_REQ = 1'b0;
      cur = {IO_REQ, F_REQ, S4_REQ};
      for (int i = 0; i < 3; i++) begin
         if (!cur[i]) begin
            if (rnd && !drop[i] && $urandom_range(0, 2) == 0)
               raise(i, 1'($urandom), 16'($urandom_range(0, 63)), 16'($urandom));
            else
               scramble(i);
         end
      end
      last_g = {IO_GNT, F_GNT, S4_GNT};
      last_v = {IO_RVALID, F_RVALID, S4_RVALID};
      if (last_v != 3'b000) rv_total++;
   endtask

   task automatic wait_sig(input bit rv, input int i, input int lim, output int at);
      logic [2:0] v;
      at = -1;
      for (int k = 0; k < lim; k++) begin
         step();
         v = rv ? last_v : last_g;
         if (v[i]) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_%s_%0d: no pulse within %0d cycles", rv ? "rvalid" : "gnt", i, lim);
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 300; k++) begin
         if ({IO_REQ, F_REQ, S4_REQ} == 3'b000 && !BUSY && gq.size() == 0 && vq.size() == 0) break;
         step();
      end
   endtask

   int t, at, n_s4, rv0;
   int gc[3];

   initial begin
      S4_REQ = 0; S4_WE = 0; S4_ADDR = '0; S4_WDATA = '0;
      F_REQ = 0;  F_ADDR = '0;
      IO_REQ = 0; IO_WE = 0; IO_ADDR = '0; IO_WDATA = '0;
      repeat (3) step();
      RSTN = 1'b1;
      repeat (2) step();

      // Single fetch read of a preloaded word.
      raise(1, 1'b0, 16'h0010, '0);
      t = cyc;
      wait_sig(0, 1, 10, at);
      chk("fetch_gnt_lat", 32'(at - t), 32'd1);
      chk("fetch_mem_addr", 32'(MEM_ADDR), 32'h0010);
      wait_sig(1, 1, 10, at);
      chk("fetch_rvalid_lat", 32'(at - t), 32'd3);
      chk("fetch_rdata", 32'(RDATA), 32'hABCD);
      drain();

      // S4 write and fetch in the same cycle: S4 first, fetch two cycles later.
      raise(0, 1'b1, 16'h0020, 16'h5A5A);
      raise(1, 1'b0, 16'h0030, '0);
      t = cyc;
      wait_sig(0, 0, 10, at);
      chk("s4_gnt_lat", 32'(at - t), 32'd1);
      chk("s4_mem_we", 32'(MEM_WE), 32'd1);
      chk("s4_mem_wdata", 32'(MEM_WDATA), 32'h5A5A);
      wait_sig(0, 1, 10, at);
      chk("fetch_after_s4_lat", 32'(at - t), 32'd3);
      drain();

      // IO aging against a continuously requesting S4 writer.
      hold[0] = 1'b1;
      raise(0, 1'b1, 16'h0040, 16'h1111);
      raise(2, 1'b1, 16'h0041, 16'h2222);
      n_s4 = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (last_g[0]) n_s4++;
         if (last_g[2]) break;
      end
      chk("starve_s4_wins", 32'(n_s4), 32'd4);
      chk("starve_io_gnt", 32'(last_g[2]), 32'd1);
      t = cyc;
      wait_sig(0, 0, 10, at);
      chk("s4_after_io_lat", 32'(at - t), 32'd2);
      hold[0] = 1'b0;
      drain();

      // Back-to-back IO writes with REQ held and the address advanced after each grant.
      rv0 = rv_total;
      hold[2] = 1'b1;
      raise(2, 1'b1, 16'h0100, 16'hC000);
      t = cyc;
      for (int k = 0; k < 3; k++) begin
         wait_sig(0, 2, 10, gc[k]);
         if (k < 2) begin
            IO_ADDR  = 16'h0101 + 16'(k);
            IO_WDATA = 16'hC001 + 16'(k);
         end else begin
            hold[2] = 1'b0;
         end
      end
      chk("io_wr0_lat", 32'(gc[0] - t), 32'd1);
      chk("io_wr1_gap", 32'(gc[1] - gc[0]), 32'd2);
      chk("io_wr2_gap", 32'(gc[2] - gc[1]), 32'd2);
      drain();
      chk("io_wr_no_rvalid", 32'(rv_total - rv0), 32'd0);

      // Reset asserted in the WAIT cycle of an S4 read.
      raise(0, 1'b0, 16'h0005, '0);
      wait_sig(0, 0, 10, at);
      step();
      RSTN = 1'b0;
      step();
      RSTN = 1'b1;
      chk("rst_busy", 32'(BUSY), 32'd0);
      chk("rst_pulses", 32'({last_g, last_v, MEM_EN, MEM_WE}), 32'd0);
      rv0 = rv_total;
      repeat (6) step();
      chk("rst_no_rvalid", 32'(rv_total - rv0), 32'd0);

      // Random traffic from all three requesters.
      rnd = 1;
      repeat (10000) step();
      rnd = 0;
      drain();
      repeat (4) step();
      chk("drain_gq", 32'(gq.size()), 32'd0);
      chk("drain_vq", 32'(vq.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
